// File: rtl/gaa_fitness_driver_if.sv
// Register bus between the fitness driver (initiator) and the 8-bit fitness peripheral.
interface gaa_fitness_driver_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write;
    logic [7:0] writedata;
    logic       read;
    logic [7:0] readdata;

    modport master (
        output address, chipselect, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/gaa_fitness_driver.sv
// Writes two parents to the fitness peripheral, reads back their XOR and
// reduces it to a popcount-based fitness score.
module gaa_fitness_driver #(
    parameter int READ_LATENCY = 1,
    parameter bit COUNT_ONES   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  p1_in,
    input  logic [7:0]  p2_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  fitness,
    output logic [7:0]  xor_out,
    output logic [15:0] eval_count,
    gaa_fitness_driver_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_P1, S_WR_P2, S_RD_XOR, S_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t     state, state_nxt;
    logic [7:0] p1_q, p2_q;
    logic [1:0] lat_cnt;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_WR_P1;
            S_WR_P1:  state_nxt = S_WR_P2;
            S_WR_P2:  state_nxt = S_RD_XOR;
            S_RD_XOR: state_nxt = S_WAIT;
            S_WAIT:   if (lat_cnt == 2'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus and status decode only from registered state/parents, so reset drops strobes at once.
    always_comb begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 8'h00;
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        case (state)
            S_WR_P1: begin
                bus.chipselect = 1'b1;
                bus.write      = 1'b1;
                bus.address    = 2'd0;
                bus.writedata  = p1_q;
            end
            S_WR_P2: begin
                bus.chipselect = 1'b1;
                bus.write      = 1'b1;
                bus.address    = 2'd1;
                bus.writedata  = p2_q;
            end
            S_RD_XOR: begin
                bus.chipselect = 1'b1;
                bus.read       = 1'b1;
                bus.address    = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q       <= '0;
            p2_q       <= '0;
            lat_cnt    <= '0;
            xor_out    <= '0;
            fitness    <= '0;
            eval_count <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                p1_q <= p1_in;
                p2_q <= p2_in;
            end
            if (state == S_RD_XOR) lat_cnt <= LAT_INIT;
            if (state == S_WAIT) begin
                if (lat_cnt == 2'd0) begin
                    xor_out    <= bus.readdata;
                    fitness    <= COUNT_ONES ? popcount8(bus.readdata)
                                             : 4'd8 - popcount8(bus.readdata);
                    eval_count <= eval_count + 16'd1;
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gaa_fitness_driver.sv
// Directed bench: three driver builds (default, matching-bit count, 3-cycle read latency)
// each talking to its own register-file peripheral model.
module tb_gaa_fitness_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  p1, p2;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [3:0]  fit0, fit1, fit2;
    logic [7:0]  xor0, xor1, xor2;
    logic [15:0] cnt0, cnt1, cnt2;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_cnt;

    gaa_fitness_driver_if bus0();
    gaa_fitness_driver_if bus1();
    gaa_fitness_driver_if bus2();

    always #5 clk = ~clk;

    gaa_fitness_driver #(.READ_LATENCY(1), .COUNT_ONES(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .start(start_a), .p1_in(p1), .p2_in(p2),
        .busy(busy0), .done(done0), .fitness(fit0), .xor_out(xor0),
        .eval_count(cnt0), .bus(bus0));

    gaa_fitness_driver #(.READ_LATENCY(1), .COUNT_ONES(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .start(start_a), .p1_in(p1), .p2_in(p2),
        .busy(busy1), .done(done1), .fitness(fit1), .xor_out(xor1),
        .eval_count(cnt1), .bus(bus1));

    gaa_fitness_driver #(.READ_LATENCY(3), .COUNT_ONES(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .start(start_b), .p1_in(p1), .p2_in(p2),
        .busy(busy2), .done(done2), .fitness(fit2), .xor_out(xor2),
        .eval_count(cnt2), .bus(bus2));

    // Peripheral models: reg0/reg1 writable, reg2 returns reg0^reg1 after the
    // configured latency and 0 in every other cycle.
    logic [7:0] m0_r0, m0_r1, m0_rd;
    logic [7:0] m1_r0, m1_r1, m1_rd;
    logic [7:0] m2_r0, m2_r1;
    logic [7:0] m2_pipe [3];

    always @(posedge clk) begin
        if (bus0.chipselect && bus0.write && bus0.address == 2'd0) m0_r0 <= bus0.writedata;
        if (bus0.chipselect && bus0.write && bus0.address == 2'd1) m0_r1 <= bus0.writedata;
        m0_rd <= (bus0.chipselect && bus0.read && bus0.address == 2'd2) ? (m0_r0 ^ m0_r1) : 8'h00;
        if (bus1.chipselect && bus1.write && bus1.address == 2'd0) m1_r0 <= bus1.writedata;
        if (bus1.chipselect && bus1.write && bus1.address == 2'd1) m1_r1 <= bus1.writedata;
        m1_rd <= (bus1.chipselect && bus1.read && bus1.address == 2'd2) ? (m1_r0 ^ m1_r1) : 8'h00;
        if (bus2.chipselect && bus2.write && bus2.address == 2'd0) m2_r0 <= bus2.writedata;
        if (bus2.chipselect && bus2.write && bus2.address == 2'd1) m2_r1 <= bus2.writedata;
        m2_pipe[0] <= (bus2.chipselect && bus2.read && bus2.address == 2'd2) ? (m2_r0 ^ m2_r1) : 8'h00;
        m2_pipe[1] <= m2_pipe[0];
        m2_pipe[2] <= m2_pipe[1];
    end

    assign bus0.readdata = m0_rd;
    assign bus1.readdata = m1_rd;
    assign bus2.readdata = m2_pipe[2];

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] exp_xor;
        logic [3:0] exp_fit;
        logic [3:0] exp_match;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start both latency builds together; default done lands in cycle 5, RL=3 in cycle 7.
    task automatic run_eval(input vec_t v);
        int c0, c2, nd0;
        logic [7:0] rd2_early;
        c0 = 0; c2 = 0; nd0 = 0; rd2_early = 8'h00;
        p1 = v.p1; p2 = v.p2;
        start_a = 1'b1; start_b = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (done0) begin
                nd0++;
                if (c0 == 0) c0 = c;
            end
            if (done2 && c2 == 0) c2 = c;
            if (c == 5) rd2_early = bus2.readdata;
            if (c == 6) chk("rl3 readdata cycle6", {24'h0, bus2.readdata}, {24'h0, v.exp_xor});
            step();
        end
        exp_cnt = exp_cnt + 16'd1;
        chk("done cycle", c0, 5);
        chk("done width", nd0, 1);
        chk("xor_out", {24'h0, xor0}, {24'h0, v.exp_xor});
        chk("fitness ones", {28'h0, fit0}, {28'h0, v.exp_fit});
        chk("fitness match", {28'h0, fit1}, {28'h0, v.exp_match});
        chk("eval_count", {16'h0, cnt0}, {16'h0, exp_cnt});
        chk("rl3 done cycle", c2, 7);
        chk("rl3 xor_out", {24'h0, xor2}, {24'h0, v.exp_xor});
        if (v.exp_xor != 8'h00)
            chk("rl3 early sample differs", {31'h0, rd2_early != v.exp_xor}, 32'd1);
    endtask

    initial begin
        int nd, guard;
        logic any_act, prev_done;

        vecs[0] = '{p1: 8'hF0, p2: 8'h0F, exp_xor: 8'hFF, exp_fit: 4'd8, exp_match: 4'd0};
        vecs[1] = '{p1: 8'hA5, p2: 8'hA5, exp_xor: 8'h00, exp_fit: 4'd0, exp_match: 4'd8};
        vecs[2] = '{p1: 8'h01, p2: 8'h03, exp_xor: 8'h02, exp_fit: 4'd1, exp_match: 4'd7};
        vecs[3] = '{p1: 8'h12, p2: 8'h34, exp_xor: 8'h26, exp_fit: 4'd3, exp_match: 4'd5};
        vecs[4] = '{p1: 8'hC3, p2: 8'h5A, exp_xor: 8'h99, exp_fit: 4'd4, exp_match: 4'd4};
        vecs[5] = '{p1: 8'h80, p2: 8'h00, exp_xor: 8'h80, exp_fit: 4'd1, exp_match: 4'd7};

        start_a = 1'b0; start_b = 1'b0; p1 = 8'h00; p2 = 8'h00;
        reset = 1'b1;
        #2;
        chk("reset busy", {31'h0, busy0}, 0);
        chk("reset done", {31'h0, done0}, 0);
        chk("reset fitness", {28'h0, fit0}, 0);
        chk("reset xor_out", {24'h0, xor0}, 0);
        chk("reset eval_count", {16'h0, cnt0}, 0);
        chk("reset bus", {19'h0, bus0.address, bus0.chipselect, bus0.write, bus0.read, bus0.writedata}, 0);
        step(); step();
        reset = 1'b0;
        exp_cnt = 16'h0000;
        step();

        // First evaluation with cycle-by-cycle bus checks.
        p1 = 8'hF0; p2 = 8'h0F; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("c1 write p1", {19'h0, bus0.address, bus0.chipselect, bus0.write, bus0.read, bus0.writedata},
            {19'h0, 2'd0, 1'b1, 1'b1, 1'b0, 8'hF0});
        chk("c1 busy", {31'h0, busy0}, 1);
        step();
        chk("c2 write p2", {19'h0, bus0.address, bus0.chipselect, bus0.write, bus0.read, bus0.writedata},
            {19'h0, 2'd1, 1'b1, 1'b1, 1'b0, 8'h0F});
        step();
        chk("c3 read xor", {19'h0, bus0.address, bus0.chipselect, bus0.write, bus0.read},
            {19'h0, 2'd2, 1'b1, 1'b0, 1'b1});
        step();
        chk("c4 bus idle", {30'h0, bus0.chipselect, done0}, 0);
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("c5 done", {31'h0, done0}, 1);
        chk("c5 xor_out", {24'h0, xor0}, 32'hFF);
        chk("c5 fitness", {28'h0, fit0}, 8);
        chk("c5 eval_count", {16'h0, cnt0}, {16'h0, exp_cnt});
        chk("c5 busy", {31'h0, busy0}, 1);
        step();
        chk("c6 done low", {31'h0, done0}, 0);
        chk("c6 busy low", {31'h0, busy0}, 0);
        step();
        exp_cnt = cnt0;  // d0 and d1 share start; d1 ran too
        exp_cnt = 16'h0001;

        foreach (vecs[i]) run_eval(vecs[i]);

        // Starts during WR_P2 and DONE are ignored; parents latched at acceptance only.
        p1 = 8'h01; p2 = 8'h03; start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        chk("busy-start c2 writedata", {24'h0, bus0.writedata}, 32'h03);
        start_a = 1'b1; p1 = 8'hFF; p2 = 8'h00;
        step();
        start_a = 1'b0;
        chk("busy-start c3 read", {30'h0, bus0.read, bus0.write}, 32'd2);
        step(); step();
        exp_cnt = exp_cnt + 16'd1;
        chk("busy-start done", {31'h0, done0}, 1);
        chk("busy-start fitness", {28'h0, fit0}, 1);
        chk("busy-start xor", {24'h0, xor0}, 32'h02);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("busy-start busy falls", {31'h0, busy0}, 0);
        any_act = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus0.chipselect || done0 || busy0) any_act = 1'b1;
            step();
        end
        chk("busy-start no extra activity", {31'h0, any_act}, 0);
        chk("busy-start eval_count", {16'h0, cnt0}, {16'h0, exp_cnt});

        // Asynchronous reset in the middle of WR_P2.
        p1 = 8'hAA; p2 = 8'h55; start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("async reset strobes", {29'h0, bus0.chipselect, bus0.write, bus0.read}, 0);
        chk("async reset eval_count", {16'h0, cnt0}, 0);
        chk("async reset busy", {31'h0, busy0}, 0);
        step();
        reset = 1'b0;
        exp_cnt = 16'h0000;
        any_act = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done0 || bus0.chipselect) any_act = 1'b1;
            step();
        end
        chk("after reset no done", {31'h0, any_act}, 0);
        p1 = 8'h3C; p2 = 8'h00; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c < 8; c++) step();
        exp_cnt = exp_cnt + 16'd1;
        chk("post-reset fitness", {28'h0, fit0}, 4);
        chk("post-reset eval_count", {16'h0, cnt0}, {16'h0, exp_cnt});

        // Counter wrap with start held high for back-to-back evaluations.
        force u_d0.eval_count = 16'hFFFD;
        #1;
        release u_d0.eval_count;
        exp_cnt = 16'hFFFD;
        start_a = 1'b1;
        nd = 0; guard = 0; prev_done = 1'b0;
        while (nd < 5 && guard < 60) begin
            step();
            guard++;
            if (prev_done && done0) chk("b2b done width", 1, 0);
            if (done0) begin
                nd++;
                exp_cnt = exp_cnt + 16'd1;
                chk("b2b eval_count", {16'h0, cnt0}, {16'h0, exp_cnt});
                if (nd == 5) start_a = 1'b0;
            end
            prev_done = done0;
        end
        chk("b2b done count", nd, 5);
        chk("b2b wrapped count", {16'h0, cnt0}, 32'h0002);
        step(); step();
        chk("b2b idle", {31'h0, busy0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
